// File: rtl/button_pkg.sv
// Shared types and timing constants for the push-button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } debounce_state_t;

    localparam int unsigned GLITCH_CNT_W = 8;
    localparam int unsigned CLK_HZ       = 50_000_000;
    // 1 ms of stability at the default clock rate.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 1000;

endpackage

// File: rtl/button_debounce_sync_chain.sv
// sync_chain: plain multi-flop synchroniser for asynchronous inputs, cleared on
// synchronous active-low reset.
module sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];

    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < int'(STAGES); i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronises a bouncing button level and emits a clean level
// plus a one-cycle change strobe. BUTTON_DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic changed
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_in;
    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            out_q, out_d;
    logic            changed_q, changed_d;

    sync_chain #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (sync_in)
    );

    // Stability check: the counter only runs while a candidate level is held.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        out_d     = out_q;
        changed_d = 1'b0;
        unique case (state_q)
            LOW: begin
                if (sync_in) state_d = RISE_CHK;
            end
            RISE_CHK: begin
                if (!sync_in) begin
                    state_d = LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HIGH;
                    out_d     = 1'b1;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync_in) state_d = FALL_CHK;
            end
            FALL_CHK: begin
                if (sync_in) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = LOW;
                    out_d     = 1'b0;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= LOW;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    assign out     = out_q;
    assign changed = changed_q;

`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    logic                    reject_c;
    logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

    // Saturating count of candidate levels that bounced back before settling.
    always_comb begin
        reject_c = ((state_q == RISE_CHK) && !sync_in) ||
                   ((state_q == FALL_CHK) &&  sync_in);
        glitch_d = glitch_q;
        if (reject_c && (glitch_q != {GLITCH_CNT_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: two instances (4/2 and 1/3 timing) share
// stimulus and are checked cycle by cycle against a run-length reference model.
module tb_button_debounce;
    import button_pkg::*;

    localparam int unsigned D_A = 4;
    localparam int unsigned S_A = 2;
    localparam int unsigned D_B = 1;
    localparam int unsigned S_B = 3;

    logic clk = 1'b0;
    logic reset;
    logic in;
    logic out_a, ch_a, out_b, ch_b;
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] gl_a, gl_b;
`endif

    button_debounce #(.DEBOUNCE_CYCLES(D_A), .SYNC_STAGES(S_A)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .out        (out_a),
        .changed    (ch_a)
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (gl_a)
`endif
    );

    button_debounce #(.DEBOUNCE_CYCLES(D_B), .SYNC_STAGES(S_B)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .out        (out_b),
        .changed    (ch_b)
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (gl_b)
`endif
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic o;
        logic c;
        int   g;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state: raw sample history, current clean level, length of
    // the current run of samples disagreeing with it, and rejected-run count.
    logic hist [2][4];
    logic m_out [2];
    int   m_run [2];
    int   m_gl  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A level change is accepted after D+1 consecutive synchronised samples
    // that disagree with the current level; a shorter run counts as a glitch.
    task automatic model_step(input int id, input logic rst, input logic din, output exp_t e);
        int   d;
        int   s;
        logic smp;
        logic chg;
        d   = (id == 0) ? int'(D_A) : int'(D_B);
        s   = (id == 0) ? int'(S_A) : int'(S_B);
        chg = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) hist[id][i] = 1'b0;
            m_out[id] = 1'b0;
            m_run[id] = 0;
            m_gl[id]  = 0;
        end else begin
            smp = hist[id][s-1];
            if (smp == m_out[id]) begin
                if (m_run[id] > 0 && m_gl[id] < 255) m_gl[id]++;
                m_run[id] = 0;
            end else begin
                m_run[id]++;
                if (m_run[id] == d + 1) begin
                    m_out[id] = ~m_out[id];
                    chg       = 1'b1;
                    m_run[id] = 0;
                end
            end
            for (int i = 3; i > 0; i--) hist[id][i] = hist[id][i-1];
            hist[id][0] = din;
        end
        e.o = m_out[id];
        e.c = chg;
        e.g = m_gl[id];
    endtask

    always @(posedge clk) begin : model_proc
        exp_t e;
        model_step(0, reset, in, e);
        q_a.push_back(e);
        model_step(1, reset, in, e);
        q_b.push_back(e);
    end

    always @(negedge clk) begin : monitor_proc
        exp_t e;
        if (q_a.size() == 0) begin
            chk("scoreboard_a_empty", 32'd0, 32'd1);
        end else begin
            e = q_a.pop_front();
            chk("out_a", 32'(out_a), 32'(e.o));
            chk("changed_a", 32'(ch_a), 32'(e.c));
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
            chk("glitch_a", 32'(gl_a), 32'(e.g));
`endif
        end
        if (q_b.size() == 0) begin
            chk("scoreboard_b_empty", 32'd0, 32'd1);
        end else begin
            e = q_b.pop_front();
            chk("out_b", 32'(out_b), 32'(e.o));
            chk("changed_b", 32'(ch_b), 32'(e.c));
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
            chk("glitch_b", 32'(gl_b), 32'(e.g));
`endif
        end
    end

    int chg_a = 0;
    int hi_a  = 0;
    always @(negedge clk) begin
        if (ch_a === 1'b1) chg_a++;
        if (out_a === 1'b1) hi_a++;
    end

    task automatic hold(input logic v, input int n);
        in = v;
        repeat (n) @(negedge clk);
    endtask

    // Drive a level and report the first posedge after which each out matches it.
    task automatic measure(input logic v, output int lat_a, output int lat_b);
        lat_a = 0;
        lat_b = 0;
        in    = v;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            if (lat_a == 0 && out_a === v) lat_a = n;
            if (lat_b == 0 && out_b === v) lat_b = n;
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int la, lb, c0, h0;
        reset = 1'b0;
        in    = 1'b1;

        // Reset held with the button pressed.
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_a", 32'(out_a), 32'd0);
            chk("rst_changed_a", 32'(ch_a), 32'd0);
            chk("rst_out_b", 32'(out_b), 32'd0);
        end
        c0 = chg_a;
        reset = 1'b1;
        measure(1'b1, la, lb);
        chk("release_lat_a", 32'(la), 32'd7);
        chk("release_lat_b", 32'(lb), 32'd5);
        chk("release_pulses_a", 32'(chg_a - c0), 32'd1);
        hold(1'b0, 20);

        // Clean press and release.
        c0 = chg_a;
        measure(1'b1, la, lb);
        chk("press_lat_a", 32'(la), 32'd7);
        chk("press_lat_b", 32'(lb), 32'd5);
        hold(1'b1, 20);
        measure(1'b0, la, lb);
        chk("release2_lat_a", 32'(la), 32'd7);
        chk("release2_lat_b", 32'(lb), 32'd5);
        hold(1'b0, 20);
        chk("clean_pulses_a", 32'(chg_a - c0), 32'd2);

        // Bounce before a stable press.
        c0 = chg_a;
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 2);
        measure(1'b1, la, lb);
        chk("bounce_lat_a", 32'(la), 32'd7);
        chk("bounce_pulses_a", 32'(chg_a - c0), 32'd1);
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        chk("bounce_glitch_a", 32'(gl_a), 32'd2);
`endif
        hold(1'b1, 10);
        hold(1'b0, 20);

        // Short glitch from LOW.
        c0 = chg_a;
        h0 = hi_a;
        hold(1'b1, 3);
        hold(1'b0, 20);
        chk("glitch_pulses_a", 32'(chg_a - c0), 32'd0);
        chk("glitch_high_a", 32'(hi_a - h0), 32'd0);

        // Reset in the middle of a rising check.
        in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midchk_state_a", 32'(dut_a.state_q), 32'(RISE_CHK));
        chk("midchk_cnt_a", 32'(dut_a.cnt_q), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_state_a", 32'(dut_a.state_q), 32'(LOW));
        chk("midrst_cnt_a", 32'(dut_a.cnt_q), 32'd0);
        chk("midrst_out_a", 32'(out_a), 32'd0);
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        chk("midrst_glitch_a", 32'(gl_a), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        hold(1'b0, 20);

        // Random bursts of varying length.
        for (int i = 0; i < 60; i++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
        end
        hold(1'b0, 20);

        // Alternating input every cycle drives the glitch counters to saturation.
        @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 2);
        reset = 1'b1;
        for (int i = 0; i < 600; i++) begin
            hold(1'(i % 2 == 0), 1);
        end
        hold(1'b0, 20);
`ifdef BUTTON_DEBOUNCE_GLITCH_CNT_EN
        chk("sat_glitch_a", 32'(gl_a), 32'd255);
        chk("sat_glitch_b", 32'(gl_b), 32'd255);
`endif
        measure(1'b1, la, lb);
        chk("final_lat_a", 32'(la), 32'd7);
        chk("final_lat_b", 32'(lb), 32'd5);
        hold(1'b1, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the edge-detect/pulse block.
- Takes a raw, asynchronous, bouncing push-button or switch level and synchronises it into `clk`.
- Filters bounce with a stability counter and outputs a clean level, `out`, which feeds the edge-detect block's `in`.
- Also emits a one-cycle `changed` strobe whenever `out` toggles.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised samples required before `out` follows the input (1 ms at 50 MHz). Legal range ≥ 1.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser. Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of the stability counter. Derived; do not override.

Ports:
- clk      input   1      system clock; all logic on posedge.
- reset    input   1      synchronous, active-low reset (0 = reset).
- in       input   1      raw asynchronous button level, active-high.
- out      output  1      debounced level.
- changed  output  1      one-cycle pulse in the cycle `out` changes value.

Behaviour:
- Reset (`reset` == 0 at posedge):
  - Synchroniser flops cleared to 0; `sync_in` = 0.
  - State = LOW, counter = 0, `out` = 0, `changed` = 0.
  - Reset overrides all other activity, including mid-check and mid-transition.
- Synchroniser:
  - SYNC_STAGES-deep shift chain on `in`. The last stage is `sync_in`.
  - No other logic may read `in` directly.
- FSM (registered state, combinational next state):
  - LOW: `out` = 0. If `sync_in` = 1 → RISE_CHK, counter ← 0.
  - RISE_CHK:
    - If `sync_in` = 0 → LOW (bounce rejected; `out` unchanged).
    - Else if counter == DEBOUNCE_CYCLES−1 → HIGH, `out` ← 1, `changed` ← 1.
    - Else counter ← counter + 1.
  - HIGH: `out` = 1. If `sync_in` = 0 → FALL_CHK, counter ← 0.
  - FALL_CHK: mirror of RISE_CHK with the polarity inverted. Completion → LOW, `out` ← 0, `changed` ← 1.
- `out` and `changed` are registered outputs. `changed` is high for exactly one cycle per toggle and 0 otherwise.
- Latency:
  - With `in` rising before posedge 1 and held stable, `out` = 1 after posedge SYNC_STAGES + DEBOUNCE_CYCLES + 1.
  - Falling edge has the same latency.
- Any input pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes `out`.
- Counter never exceeds DEBOUNCE_CYCLES−1, so no wrap is possible. It is don't-care in LOW/HIGH but held at 0 there.
- DEBOUNCE_CYCLES = 1: the check state lasts exactly one cycle.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output port `glitch_cnt` [7:0], reset to 0.
  - Increments by 1 each time RISE_CHK → LOW or FALL_CHK → HIGH (rejected bounce).
  - Saturates at 255.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package `button_pkg`:
  - `debounce_state_t` enum {LOW, RISE_CHK, HIGH, FALL_CHK}.
  - Localparam GLITCH_CNT_W = 8.
  - Default-timing constant CLK_HZ = 50_000_000, used to derive DEBOUNCE_CYCLES at top level.
- One sub-module, `sync_chain` (params: WIDTH = 1, STAGES; ports: `clk`, `reset`, `d`, `q`):
  - Plain flop chain, reset to 0.
  - Reused for other asynchronous inputs.

Test Plan (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2 unless noted):
1. Reset held low for 3 cycles with `in` = 1 → `out` = 0 and `changed` = 0 throughout; after release, `out` rises after posedge 7 post-release, with `changed` = 1 in that cycle only.
2. Clean press: `in` 0→1 held 20 cycles → `out` = 1 after exactly 7 posedges. Release → `out` = 0 after 7 posedges. Exactly two `changed` pulses in total.
3. Bounce: `in` toggles 1,0,1,0 every 2 cycles, then holds 1 → `out` remains 0 until 7 posedges after the final stable rise. Exactly one `changed` pulse. With BUTTON_DEBOUNCE_GLITCH_CNT_EN, `glitch_cnt` = 2.
4. Short glitch: 3-cycle high pulse from LOW → `out` never asserts, `changed` never pulses.
5. Reset mid-check: assert reset while in RISE_CHK with counter = 2 → next cycle state LOW, `out` = 0, counter = 0, `glitch_cnt` = 0 when the feature is enabled.
6. DEBOUNCE_CYCLES = 1, SYNC_STAGES = 3: stable press → `out` = 1 after posedge 5. With the feature enabled, 300 rejected bounces → `glitch_cnt` saturates at 255.
